// File: rtl/regfile_controller_if.sv
// Register-file access bus: two read ports with a request/valid handshake,
// one write port, and a ready flag.
interface regfile_controller_if;
  logic [4:0]  read_register_1;
  logic [4:0]  read_register_2;
  logic        rd_req;
  logic        write_reg_control;
  logic [4:0]  write_reg_to_memory;
  logic [31:0] write_data_to_memory;
  logic [31:0] read_data_1_from_memory_controller;
  logic [31:0] read_data_2_from_memory_controller;
  logic        rd_valid;
  logic        ready;

  modport master (
    output read_register_1,
    output read_register_2,
    output rd_req,
    output write_reg_control,
    output write_reg_to_memory,
    output write_data_to_memory,
    input  read_data_1_from_memory_controller,
    input  read_data_2_from_memory_controller,
    input  rd_valid,
    input  ready
  );

  modport slave (
    input  read_register_1,
    input  read_register_2,
    input  rd_req,
    input  write_reg_control,
    input  write_reg_to_memory,
    input  write_data_to_memory,
    output read_data_1_from_memory_controller,
    output read_data_2_from_memory_controller,
    output rd_valid,
    output ready
  );
endinterface

// File: rtl/regfile_controller.sv
// 32x32 register file with x0 hard-wired to zero, a post-reset init sweep,
// registered dual-port reads and write-first same-edge bypass.
module regfile_controller #(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_controller_if.slave  bus
);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [4:0]  cnt_r;
  logic [31:0] mem_r [0:31];
  logic [31:0] rdata_1_r;
  logic [31:0] rdata_2_r;
  logic        rd_valid_r;
  logic        wr_en_s;
  logic        rd_en_s;
  logic [31:0] rd_1_s;
  logic [31:0] rd_2_s;

  // Next-state decode: leave INIT on the edge that clears x31.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      INIT: begin
        if (cnt_r == 5'd31) begin
          next_state_s = RUN;
        end else begin
          next_state_s = INIT;
        end
      end
      RUN:     next_state_s = RUN;
      default: next_state_s = INIT;
    endcase
  end

  // Access qualification and read muxing with write-first bypass.
  always_comb begin
    wr_en_s = (state_r == RUN) && bus.write_reg_control &&
              (bus.write_reg_to_memory != 5'd0);
    rd_en_s = (state_r == RUN) && bus.rd_req;
    rd_1_s  = 32'h0000_0000;
    rd_2_s  = 32'h0000_0000;
    if (bus.read_register_1 == 5'd0) begin
      rd_1_s = 32'h0000_0000;
    end else if (wr_en_s && (bus.write_reg_to_memory == bus.read_register_1)) begin
      rd_1_s = bus.write_data_to_memory;
    end else begin
      rd_1_s = mem_r[bus.read_register_1];
    end
    if (bus.read_register_2 == 5'd0) begin
      rd_2_s = 32'h0000_0000;
    end else if (wr_en_s && (bus.write_reg_to_memory == bus.read_register_2)) begin
      rd_2_s = bus.write_data_to_memory;
    end else begin
      rd_2_s = mem_r[bus.read_register_2];
    end
  end

  // State register and init sweep counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= INIT;
      cnt_r   <= 5'd1;
    end else begin
      state_r <= next_state_s;
      if (state_r == INIT) begin
        cnt_r <= cnt_r + 5'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Storage update: sweep writes in INIT, qualified writes in RUN; x0 is never written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_r == INIT) begin
        mem_r[cnt_r] <= RESET_VALUE;
      end else if (wr_en_s) begin
        mem_r[bus.write_reg_to_memory] <= bus.write_data_to_memory;
      end
    end
  end

  // Registered read data and one-cycle valid pulse; data holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_1_r  <= 32'h0000_0000;
      rdata_2_r  <= 32'h0000_0000;
      rd_valid_r <= 1'b0;
    end else if (rd_en_s) begin
      rdata_1_r  <= rd_1_s;
      rdata_2_r  <= rd_2_s;
      rd_valid_r <= 1'b1;
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

  assign bus.read_data_1_from_memory_controller = rdata_1_r;
  assign bus.read_data_2_from_memory_controller = rdata_2_r;
  assign bus.rd_valid                           = rd_valid_r;
  assign bus.ready                              = (state_r == RUN);

endmodule

// File: tb/tb_regfile_controller.sv
// Directed, table-driven bench for regfile_controller: init timing, read/write,
// bypass, streaming, and reset during operation and during the sweep.
module tb_regfile_controller;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  regfile_controller_if rf_if ();

  regfile_controller #(.RESET_VALUE(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        ev;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vtab [0:18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rd, input logic [4:0] r1, input logic [4:0] r2);
    rf_if.write_reg_control    = we;
    rf_if.write_reg_to_memory  = wa;
    rf_if.write_data_to_memory = wd;
    rf_if.rd_req               = rd;
    rf_if.read_register_1      = r1;
    rf_if.read_register_2      = r2;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Holds rst for n edges with the current inputs, then checks the reset state.
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk("reset_ready",    {31'd0, rf_if.ready}, 32'd0);
    chk("reset_rd_valid", {31'd0, rf_if.rd_valid}, 32'd0);
    chk("reset_data1",    rf_if.read_data_1_from_memory_controller, 32'd0);
    chk("reset_data2",    rf_if.read_data_2_from_memory_controller, 32'd0);
    rst = 1'b0;
  endtask

  // Counts edges until ready rises (bounded) with whatever inputs are driven.
  task automatic wait_ready(input int exp_edges);
    int  n;
    logic saw_valid;
    n = 0;
    saw_valid = 1'b0;
    while (n < 100) begin
      cycle();
      n++;
      if (rf_if.rd_valid !== 1'b0) saw_valid = 1'b1;
      if (rf_if.ready === 1'b1) break;
    end
    chk("init_no_rd_valid", {31'd0, saw_valid}, 32'd0);
    chk("init_edges", n, exp_edges);
    if (rf_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL init_timeout: ready not seen within %0d edges", n);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(1'b1, 5'd9, 32'h0BAD_0BAD, 1'b1, 5'd9, 5'd9);
    do_reset(2);

    // Sweep with a write to x3 and reads requested every cycle: all ignored.
    drive(1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd3, 5'd3);
    wait_ready(31);
    chk("init_data1_held", rf_if.read_data_1_from_memory_controller, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);

    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, i[4:0], 5'(32 - i));
      cycle();
      chk("sweep_valid", {31'd0, rf_if.rd_valid}, 32'd1);
      chk("sweep_data1", rf_if.read_data_1_from_memory_controller, 32'd0);
      chk("sweep_data2", rf_if.read_data_2_from_memory_controller, 32'd0);
    end

    vtab[0]  = '{1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0,         32'h0};
    vtab[1]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 5'd0, 1'b1, 32'hDEAD_BEEF, 32'h0};
    vtab[2]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 1'b0, 32'hDEAD_BEEF, 32'h0};
    vtab[3]  = '{1'b1, 5'd7, 32'h1234_5678, 1'b1, 5'd7, 5'd7, 1'b1, 32'h1234_5678, 32'h1234_5678};
    vtab[4]  = '{1'b1, 5'd0, 32'hCAFE_F00D, 1'b1, 5'd0, 5'd0, 1'b1, 32'h0,         32'h0};
    vtab[5]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 5'd0, 1'b1, 32'h1234_5678, 32'h0};
    vtab[6]  = '{1'b1, 5'd1, 32'd1,         1'b0, 5'd0, 5'd0, 1'b0, 32'h1234_5678, 32'h0};
    vtab[7]  = '{1'b1, 5'd2, 32'd2,         1'b0, 5'd0, 5'd0, 1'b0, 32'h1234_5678, 32'h0};
    vtab[8]  = '{1'b1, 5'd3, 32'd3,         1'b0, 5'd0, 5'd0, 1'b0, 32'h1234_5678, 32'h0};
    vtab[9]  = '{1'b1, 5'd4, 32'd4,         1'b0, 5'd0, 5'd0, 1'b0, 32'h1234_5678, 32'h0};
    vtab[10] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd1, 5'd4, 1'b1, 32'd1,         32'd4};
    vtab[11] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd2, 5'd3, 1'b1, 32'd2,         32'd3};
    vtab[12] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 5'd2, 1'b1, 32'd3,         32'd2};
    vtab[13] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd4, 5'd1, 1'b1, 32'd4,         32'd1};
    vtab[14] = '{1'b1, 5'd9, 32'hA5A5_A5A5, 1'b1, 5'd9, 5'd9, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
    vtab[15] = '{1'b0, 5'd5, 32'h0,         1'b1, 5'd5, 5'd5, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vtab[16] = '{1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd5, 5'd9, 1'b1, 32'h1111_1111, 32'hA5A5_A5A5};
    vtab[17] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 1'b0, 32'h1111_1111, 32'hA5A5_A5A5};
    vtab[18] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 5'd5, 1'b1, 32'h1111_1111, 32'h1111_1111};

    for (int v = 0; v < 19; v++) begin
      drive(vtab[v].we, vtab[v].wa, vtab[v].wd, vtab[v].rd, vtab[v].r1, vtab[v].r2);
      cycle();
      chk($sformatf("vec%0d_valid", v), {31'd0, rf_if.rd_valid}, {31'd0, vtab[v].ev});
      chk($sformatf("vec%0d_data1", v), rf_if.read_data_1_from_memory_controller, vtab[v].e1);
      chk($sformatf("vec%0d_data2", v), rf_if.read_data_2_from_memory_controller, vtab[v].e2);
      chk($sformatf("vec%0d_ready", v), {31'd0, rf_if.ready}, 32'd1);
    end

    // Reset during a read burst on x9, with a simultaneous write that must be dropped.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9);
    cycle();
    chk("burst_valid", {31'd0, rf_if.rd_valid}, 32'd1);
    chk("burst_data1", rf_if.read_data_1_from_memory_controller, 32'hA5A5_A5A5);
    drive(1'b1, 5'd9, 32'hFFFF_FFFF, 1'b1, 5'd9, 5'd9);
    do_reset(1);

    // Reset again partway through the sweep; the count restarts from x1.
    repeat (10) cycle();
    chk("mid_init_ready", {31'd0, rf_if.ready}, 32'd0);
    chk("mid_init_valid", {31'd0, rf_if.rd_valid}, 32'd0);
    do_reset(1);
    wait_ready(31);

    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd5);
    cycle();
    chk("post_rst_valid", {31'd0, rf_if.rd_valid}, 32'd1);
    chk("post_rst_x9",    rf_if.read_data_1_from_memory_controller, 32'd0);
    chk("post_rst_x5",    rf_if.read_data_2_from_memory_controller, 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd7);
    cycle();
    chk("post_rst_x3",    rf_if.read_data_1_from_memory_controller, 32'd0);
    chk("post_rst_x7",    rf_if.read_data_2_from_memory_controller, 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    cycle();
    chk("idle_valid", {31'd0, rf_if.rd_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_controller.md
REGFILE_CONTROLLER -- requirements
Module: regfile_controller

Interface
REQ-001 The block SHALL have one parameter: RESET_VALUE, default 32'h0000_0000, value written into x1..x31 by the init sweep.
REQ-002 The block SHALL have these ports: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high, sampled on the rising edge of clk.
REQ-004 read_register_1  input  5  source register index, port 1.
REQ-005 read_register_2  input  5  source register index, port 2.
REQ-006 rd_req  input  1  read request; both ports are read when high and ready is high.
REQ-007 write_reg_control  input  1  write enable (RegWrite from writeback).
REQ-008 write_reg_to_memory  input  5  destination register index.
REQ-009 write_data_to_memory  input  32  write data.
REQ-010 read_data_1_from_memory_controller  output  32  registered read data, port 1.
REQ-011 read_data_2_from_memory_controller  output  32  registered read data, port 2.
REQ-012 rd_valid  output  1  one-cycle pulse; read data valid this cycle.
REQ-013 ready  output  1  high when the block accepts reads and writes.

Function
REQ-014 Storage SHALL be 32 x 32-bit; x0 SHALL always read 0, and writes to x0 SHALL be discarded.
REQ-015 The FSM SHALL have two states, INIT and RUN; ready SHALL equal (state == RUN), decoded from state only.
REQ-016 INIT: a 5-bit sweep counter starts at 1; each cycle it writes RESET_VALUE into reg[cnt] and increments.
REQ-017 INIT to RUN: on the edge that clears reg[31], the next state SHALL be RUN, so ready rises exactly 31 edges after the last edge at which rst was sampled high.
REQ-018 INIT: rd_req and write_reg_control SHALL be ignored; no register update, no rd_valid, and outputs hold 0.
REQ-019 RUN write: on an edge with write_reg_control=1 and write_reg_to_memory!=0, reg[write_reg_to_memory] SHALL take write_data_to_memory.
REQ-020 RUN read: on an edge with rd_req=1, both data outputs SHALL load the addressed contents, and rd_valid SHALL be 1 for the following cycle; latency is 1 cycle.
REQ-021 Same-edge bypass: if a valid write (REQ-019) and a read hit the same nonzero index at the same edge, that port SHALL return write_data_to_memory (write-first).
REQ-022 A read of index 0 SHALL return 0 even when a same-edge write targets index 0.
REQ-023 Both ports addressing the same index SHALL return identical data, including the bypass case.
REQ-024 Back-to-back reads SHALL be accepted every cycle with no bubble; rd_valid stays high for consecutive requests.
REQ-025 When rd_req=0, rd_valid SHALL be 0, and the data outputs SHALL hold their last values.
REQ-026 Writes SHALL be accepted every cycle independently of rd_req, with no backpressure in RUN.

Reset
REQ-027 rst=1 at an edge SHALL force: state=INIT, cnt=1, read_data_1/2=0, rd_valid=0, ready=0.
REQ-028 rst SHALL override every other input at that edge; a simultaneous write or read SHALL be dropped.
REQ-029 rst in RUN or mid-INIT SHALL restart the full sweep from x1; any pending rd_valid SHALL be cancelled.
REQ-030 Register contents SHALL be undefined only until the sweep completes; after ready=1, every xN (N>0) SHALL read RESET_VALUE until written.

Verification
REQ-031 Init: rst high 2 cycles, then low -> ready=0 for 31 edges, then 1; reading x1..x31 then returns 0 (RESET_VALUE=0).
REQ-032 Write/read: write x5=32'hDEAD_BEEF; the next cycle read x5 and x0 -> port1=DEAD_BEEF, port2=0, rd_valid=1 one cycle later.
REQ-033 Bypass: same edge, write x7=32'h1234_5678 and read x7 on both ports -> both ports return 1234_5678; a write to x0 with a read of x0 -> 0.
REQ-034 Streaming: rd_req high 4 cycles on x1..x4, preloaded with 1..4 -> rd_valid high 4 consecutive cycles, data 1,2,3,4.
REQ-035 Mid-op reset: write x9=32'hA5A5_A5A5, then assert rst during a rd_req burst -> rd_valid drops next cycle, ready=0 for 31 edges, then x9 reads 0.
REQ-036 INIT blocking: during the sweep, drive a write to x3=32'hFFFF_FFFF and rd_req=1 -> no rd_valid; after ready, x3 reads 0.
